piece_bag_gen: RTL and testbench

Parametrised successor to the tetris shape generator. It keeps a configurable Fibonacci LFSR running freely and filters its output into a preview queue of upcoming pieces. The filter supports two modes: raw (uniform over 1..7) and 7-bag (each shape exactly once per bag of seven). It sits between the game-control FSM, which pops pieces with a `Take` strobe, and the renderer, which draws the next-piece preview.

---
 rtl/tetris_rng_pkg.sv | 19 +
 rtl/lfsr_core.sv | 30 +++
 rtl/piece_bag_gen.sv | 128 ++++++++++++
 tb/tb_piece_bag_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tetris_rng_pkg.sv
// Shared types and constants for the tetris piece generators.
package tetris_rng_pkg;

    typedef logic [2:0] piece_t;

    localparam piece_t      PIECE_NONE = 3'b000;
    localparam logic [6:0]  BAG_FULL   = 7'h7F;
    localparam logic [15:0] DEF_SEED   = 16'h600D;
    localparam logic [15:0] DEF_TAPS   = 16'h002D;

    // One-hot bag bit for a piece; piece 1 maps to bit 0.
    function automatic logic [6:0] piece_bit(input piece_t p);
        piece_bit = 7'd0;
        if (p != PIECE_NONE) begin
            piece_bit[p - 3'd1] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with synchronous load; a zero load value falls back to SEED.
module lfsr_core
    import tetris_rng_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED),
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic [LFSR_W-1:0] Load_val,
    output logic [LFSR_W-1:0] State
);

    logic fb;

    assign fb = ^(State & TAPS);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            State <= SEED;
        end else if (Load) begin
            State <= (Load_val == '0) ? SEED : Load_val;
        end else begin
            State <= {fb, State[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/piece_bag_gen.sv
// Piece generator: filters LFSR candidates (raw or 7-bag) into a shift-register preview queue.
module piece_bag_gen
    import tetris_rng_pkg::*;
#(
    parameter int                LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] SEED    = LFSR_W'(DEF_SEED),
    parameter logic [LFSR_W-1:0] TAPS    = LFSR_W'(DEF_TAPS),
    parameter int                PREVIEW = 3
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            Take,
    input  logic                            Reseed,
    input  logic [LFSR_W-1:0]               Seed_in,
    input  logic                            Bag_mode,
    output logic                            Valid,
    output logic [2:0]                      Next_piece,
    output logic [3*PREVIEW-1:0]            Preview,
    output logic [$clog2(PREVIEW+2)-1:0]    Count
);

    localparam int             D     = PREVIEW + 1;
    localparam int             CW    = $clog2(PREVIEW + 2);
    localparam logic [CW-1:0]  DEPTH = CW'(D);

    logic [LFSR_W-1:0] lfsr_state;
    piece_t            cand;
    piece_t            q      [D];
    piece_t            q_next [D];
    logic [CW-1:0]     count, count_next, wr_idx;
    logic [6:0]        used, used_next, cand_bit, used_set;
    logic              pop, room, accept, push;

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED),
        .TAPS   (TAPS)
    ) u_lfsr (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (Reseed),
        .Load_val (Seed_in),
        .State    (lfsr_state)
    );

    assign cand = lfsr_state[2:0];

    // Fill filter; an all-zero LFSR can never yield a push even if the invariant were broken.
    always_comb begin
        cand_bit = piece_bit(cand);
        used_set = used | cand_bit;
        pop      = Take && (count != '0) && !Reseed;
        room     = (count != DEPTH) || pop;
        accept   = (cand != PIECE_NONE) && (|lfsr_state) &&
                   (!Bag_mode || ((used & cand_bit) == 7'd0));
        push     = !Reseed && room && accept;
    end

    always_comb begin
        used_next = used;
        if (Reseed || !Bag_mode) begin
            used_next = 7'd0;
        end else if (push) begin
            used_next = (used_set == BAG_FULL) ? 7'd0 : used_set;
        end
    end

    // Pop shifts first, so a same-cycle push lands one slot lower.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            q_next[i] = q[i];
        end
        count_next = count;
        wr_idx     = pop ? (count - CW'(1)) : count;
        if (pop) begin
            for (int i = 0; i < D - 1; i++) begin
                q_next[i] = q[i+1];
            end
            q_next[D-1] = PIECE_NONE;
        end
        if (push) begin
            for (int i = 0; i < D; i++) begin
                if (wr_idx == CW'(i)) begin
                    q_next[i] = cand;
                end
            end
        end
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
        if (Reseed) begin
            for (int i = 0; i < D; i++) begin
                q_next[i] = PIECE_NONE;
            end
            count_next = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < D; i++) begin
                q[i] <= PIECE_NONE;
            end
            count <= '0;
            used  <= 7'd0;
        end else begin
            for (int i = 0; i < D; i++) begin
                q[i] <= q_next[i];
            end
            count <= count_next;
            used  <= used_next;
        end
    end

    always_comb begin
        Preview = '0;
        for (int k = 1; k <= PREVIEW; k++) begin
            Preview[3*(k-1) +: 3] = q[k];
        end
    end

    assign Valid      = (count != '0);
    assign Next_piece = q[0];
    assign Count      = count;

endmodule

// File: tb/tb_piece_bag_gen.sv
// Self-checking bench for piece_bag_gen against a queue-based reference model.
module tb_piece_bag_gen;

    localparam int          PREVIEW = 3;
    localparam int          D       = PREVIEW + 1;
    localparam logic [15:0] SEED    = 16'h600D;
    localparam logic [15:0] TAPS    = 16'h002D;

    logic        Clk      = 1'b0;
    logic        Reset    = 1'b0;
    logic        Take     = 1'b0;
    logic        Reseed   = 1'b0;
    logic        Bag_mode = 1'b0;
    logic [15:0] Seed_in  = 16'h0000;
    logic        Valid;
    logic [2:0]  Next_piece;
    logic [8:0]  Preview;
    logic [2:0]  Count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_state;
    logic [2:0]  exp_q[$];
    bit          seen[1:7];
    logic [2:0]  pops[$];
    bit          rec_pops = 1'b0;

    always #5 Clk = ~Clk;

    piece_bag_gen #(
        .LFSR_W  (16),
        .SEED    (SEED),
        .TAPS    (TAPS),
        .PREVIEW (PREVIEW)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Take       (Take),
        .Reseed     (Reseed),
        .Seed_in    (Seed_in),
        .Bag_mode   (Bag_mode),
        .Valid      (Valid),
        .Next_piece (Next_piece),
        .Preview    (Preview),
        .Count      (Count)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (TAPS[i]) fb = fb ^ s[i];
        end
        return {fb, s[15:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_seen();
        for (int v = 1; v <= 7; v++) seen[v] = 1'b0;
    endtask

    task automatic model_reset();
        m_state = SEED;
        exp_q.delete();
        clear_seen();
    endtask

    task automatic model_step(input logic take, input logic reseed, input logic bag,
                              input logic [15:0] sd);
        logic [2:0] c;
        bit all_seen;
        if (reseed) begin
            m_state = (sd == 16'h0000) ? SEED : sd;
            exp_q.delete();
            clear_seen();
            return;
        end
        c = m_state[2:0];
        if (take && exp_q.size() > 0) void'(exp_q.pop_front());
        if (c != 3'd0 && exp_q.size() < D && (!bag || !seen[c])) begin
            exp_q.push_back(c);
            if (bag) begin
                seen[c] = 1'b1;
                all_seen = 1'b1;
                for (int v = 1; v <= 7; v++) if (!seen[v]) all_seen = 1'b0;
                if (all_seen) clear_seen();
            end
        end
        if (!bag) clear_seen();
        m_state = lfsr_next(m_state);
    endtask

    task automatic check_outputs(input string tag);
        logic [8:0] ep;
        ep = 9'd0;
        for (int k = 1; k <= PREVIEW; k++) begin
            if (k < exp_q.size()) ep[3*(k-1) +: 3] = exp_q[k];
        end
        chk({tag, ".valid"}, Valid, exp_q.size() != 0);
        chk({tag, ".next"}, Next_piece, (exp_q.size() != 0) ? exp_q[0] : 3'd0);
        chk({tag, ".preview"}, Preview, ep);
        chk({tag, ".count"}, Count, exp_q.size());
    endtask

    task automatic step(input logic take, input logic reseed, input logic bag,
                        input logic [15:0] sd, input string tag);
        Take     = take;
        Reseed   = reseed;
        Bag_mode = bag;
        Seed_in  = sd;
        if (rec_pops && take && !reseed && Valid) pops.push_back(Next_piece);
        @(posedge Clk);
        model_step(take, reseed, bag, sd);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [2:0] saved_cand;
        int         guard;
        logic [7:0] mask;
        logic       rnd_bag;

        // Power-on reset
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_outputs("reset");
        Reset = 1'b1;

        // Take while empty is ignored; first edge pushes one piece
        step(1'b1, 1'b0, 1'b0, 16'h0, "take_empty");
        chk("take_empty.count_is_1", Count, 3'd1);

        // Asynchronous reset mid-cycle with a partly filled queue
        #2 Reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst.valid", Valid, 1'b0);
        chk("async_rst.next", Next_piece, 3'd0);
        chk("async_rst.preview", Preview, 9'd0);
        chk("async_rst.count", Count, 3'd0);
        @(posedge Clk);
        #1;
        check_outputs("in_reset");
        Reset = 1'b1;

        // Raw fill from the default seed: 5, 6, 3, 1
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0, "fill");
        chk("fill.next_5", Next_piece, 3'd5);
        chk("fill.preview_136", Preview, 9'b001_011_110);
        chk("fill.count_4", Count, 3'd4);
        chk("fill.valid", Valid, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h0, "reject");
        chk("reject.count_4", Count, 3'd4);

        // Single Take on a full queue while the candidate is nonzero
        guard = 0;
        while (m_state[2:0] == 3'd0 && guard < 64) begin
            step(1'b0, 1'b0, 1'b0, 16'h0, "wait_cand");
            guard++;
        end
        saved_cand = m_state[2:0];
        step(1'b1, 1'b0, 1'b0, 16'h0, "take_full");
        chk("take_full.head_6", Next_piece, 3'd6);
        chk("take_full.count_4", Count, 3'd4);
        chk("take_full.slot3", Preview[8:6], saved_cand);

        // Reseed with zero seed and Take on a full queue
        step(1'b1, 1'b1, 1'b0, 16'h0, "reseed");
        chk("reseed.count_0", Count, 3'd0);
        chk("reseed.valid_0", Valid, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0, "refill");
        chk("refill.next_5", Next_piece, 3'd5);
        chk("refill.preview_136", Preview, 9'b001_011_110);
        chk("refill.count_4", Count, 3'd4);

        // Randomised mix of takes, mode switches and reseeds
        rnd_bag = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            logic        r_take, r_reseed;
            logic [15:0] r_seed;
            if ($urandom_range(0, 99) == 0) rnd_bag = ~rnd_bag;
            r_take   = 1'($urandom_range(0, 1));
            r_reseed = ($urandom_range(0, 63) == 0);
            r_seed   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(0, 65535));
            step(r_take, r_reseed, rnd_bag, r_seed, "random");
        end

        // Bag mode, Take every cycle, 700 pops from a fresh bag
        step(1'b0, 1'b1, 1'b1, 16'($urandom_range(1, 65535)), "bag_start");
        pops.delete();
        rec_pops = 1'b1;
        guard = 0;
        while (pops.size() < 700 && guard < 20000) begin
            step(1'b1, 1'b0, 1'b1, 16'h0, "bag");
            guard++;
        end
        rec_pops = 1'b0;
        chk("bag.pop_total", pops.size(), 700);
        for (int g = 0; g < pops.size() / 7; g++) begin
            mask = 8'd0;
            for (int j = 0; j < 7; j++) mask[pops[g*7 + j]] = 1'b1;
            chk("bag.permutation", mask, 8'hFE);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
